hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: cycles of dmem_ready low tolerated in MEM_WAIT before entering ERROR.
REQ-002 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports rs1_ID, rs2_ID  input  5 each  source registers of the instruction in ID.
REQ-006 SHALL have ports use_rs1_ID, use_rs2_ID  input  1 each  ID instruction actually reads rs1/rs2.
REQ-007 SHALL have ports rd_EX  input  5, and MemRead_EX  input  1  destination register and load flag of the EX instruction.
REQ-008 SHALL have port branch_taken_EX  input  1  resolved taken branch or jump in EX.
REQ-009 SHALL have ports mem_req_MEM  input  1  load/store valid in MEM, and dmem_ready  input  1  data memory completes this cycle.
REQ-010 SHALL have outputs stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM  1 each  hold the register's current contents.
REQ-011 SHALL have outputs flush_IF_ID, flush_ID_EX, flush_MEM_WB  1 each  load the register with a NOP bubble (all fields 0).
REQ-012 SHALL have outputs state  2  (RUN=0, MEM_WAIT=1, ERROR=2), and mem_err  1  sticky timeout flag.
REQ-013 SHALL have outputs stall_cycles and flush_count  CNT_W each  performance counters.

Function
REQ-014 SHALL implement FSM RUN, MEM_WAIT, ERROR; control outputs are combinational from state and inputs (Mealy).
REQ-015 SHALL define mem_stall = (state==RUN && mem_req_MEM && !dmem_ready) || state==MEM_WAIT && !dmem_ready || state==ERROR.
REQ-016 On mem_stall: stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM =1; flush_MEM_WB =1; all other flushes 0.
REQ-017 RUN -> MEM_WAIT when mem_req_MEM && !dmem_ready; MEM_WAIT -> RUN in the cycle dmem_ready=1 (no stall that cycle).
REQ-018 A wait counter SHALL clear on entering MEM_WAIT, increment each MEM_WAIT cycle; when it reaches MAX_WAIT with dmem_ready=0 the FSM SHALL go to ERROR.
REQ-019 ERROR SHALL hold mem_err=1 and full stall until reset; dmem_ready ignored in ERROR.
REQ-020 Without mem_stall, branch_taken_EX=1 SHALL assert flush_IF_ID and flush_ID_EX for exactly that cycle; no stalls.
REQ-021 Load-use SHALL be detected when MemRead_EX && rd_EX!=0 && ((use_rs1_ID && rs1_ID==rd_EX) || (use_rs2_ID && rs2_ID==rd_EX)).
REQ-022 Load-use without mem_stall or branch SHALL assert stall_PC, stall_IF_ID, flush_ID_EX for one cycle.
REQ-023 Priority SHALL be mem_stall > branch flush > load-use; lower-priority events are suppressed, re-evaluated on later cycles from held inputs.
REQ-024 stall_cycles SHALL increment each cycle stall_PC=1; flush_count SHALL increment each cycle a branch flush (REQ-020) is issued; both saturate at all-ones.

Reset
REQ-025 While reset=1, all control outputs SHALL be 0, irrespective of other inputs.
REQ-026 At the first posedge with reset=1: state=RUN, wait counter=0, mem_err=0, stall_cycles=0, flush_count=0.
REQ-027 Reset asserted mid-MEM_WAIT or in ERROR SHALL return to RUN next cycle with no residual stall.

Structure
REQ-028 State encodings and the NOP/bubble constant SHALL live in the shared pipeline package used by all stage registers.
REQ-029 One sub-module, sat_counter (parameter width, inc, clear), SHALL implement both performance counters.
REQ-030 The wait counter width SHALL be $clog2(MAX_WAIT+1).

Verification
REQ-031 rd_EX=5, MemRead_EX=1, rs1_ID=5, use_rs1_ID=1 -> stall_PC=stall_IF_ID=flush_ID_EX=1 one cycle; stall_cycles=1.
REQ-032 Same as REQ-031 but rd_EX=0 -> no stall, no flush.
REQ-033 branch_taken_EX=1 together with load-use -> flush_IF_ID=flush_ID_EX=1, stall_PC=0; flush_count=1.
REQ-034 mem_req_MEM=1, dmem_ready low 3 cycles then high -> 3 cycles full stall with flush_MEM_WB=1, state MEM_WAIT, RUN after ready; stall_cycles=3.
REQ-035 dmem_ready held low 20 cycles with MAX_WAIT=15 -> ERROR, mem_err=1, stall held; reset -> RUN, mem_err=0, counters 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared pipeline definitions used by the hazard controller and by the stage
// registers it steers.
//   state_e     : hazard FSM encoding (RUN=0, MEM_WAIT=1, ERROR=2)
//   NOP_BUBBLE  : value a stage register loads when it is flushed
//   hz_ctrl_t   : bundle of the seven stall/flush control lines
//   is_load_use : load-use dependency test between the EX load and ID sources
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    localparam int INSTR_W = 32;

    // A flushed stage register carries an all-zero bubble in every field.
    localparam logic [INSTR_W-1:0] NOP_BUBBLE = '0;

    typedef struct packed {
        logic stall_pc;
        logic stall_if_id;
        logic stall_id_ex;
        logic stall_ex_mem;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_mem_wb;
    } hz_ctrl_t;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    function automatic logic is_load_use(
        input logic       mem_read_ex,
        input logic [4:0] rd_ex,
        input logic [4:0] rs1_id,
        input logic       use_rs1_id,
        input logic [4:0] rs2_id,
        input logic       use_rs2_id
    );
        return mem_read_ex && (rd_ex != 5'd0) &&
               ((use_rs1_id && (rs1_id == rd_ex)) ||
                (use_rs2_id && (rs2_id == rd_ex)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the hazard performance counters.
//   clk   : clock
//   clear : synchronous clear to zero (dominates inc)
//   inc   : add one this cycle unless already all-ones
//   count : current counter value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: stalls on slow data memory (with a timeout into
// a sticky ERROR state), flushes the front end on taken branches, and inserts
// a one-cycle bubble on load-use dependencies. Priority is
// memory stall > branch flush > load-use.
//   clk, reset                     : clock, synchronous active-high reset
//   rs1_ID, rs2_ID, use_rs*_ID     : source registers read by the ID instruction
//   rd_EX, MemRead_EX              : destination / load flag of the EX instruction
//   branch_taken_EX                : taken branch or jump resolved in EX
//   mem_req_MEM, dmem_ready        : MEM access valid / data memory done
//   stall_*                        : hold the named pipeline register
//   flush_*                        : load the named register with a bubble
//   state, mem_err                 : FSM state and sticky timeout flag
//   stall_cycles, flush_count      : saturating performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             use_rs1_ID,
    input  logic             use_rs2_ID,
    input  logic [4:0]       rd_EX,
    input  logic             MemRead_EX,
    input  logic             branch_taken_EX,
    input  logic             mem_req_MEM,
    input  logic             dmem_ready,
    output logic             stall_PC,
    output logic             stall_IF_ID,
    output logic             stall_ID_EX,
    output logic             stall_EX_MEM,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_MEM_WB,
    output logic [1:0]       state,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_err_q, mem_err_d;

    logic     mem_stall;
    logic     load_use;
    logic     branch_flush;
    hz_ctrl_t ctrl;

    // ---------------------------------------------------------------------
    // Next-state and Mealy control outputs
    // ---------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred; blocking '=' keeps
    // later assignments overriding the defaults in order.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        mem_err_d = mem_err_q;

        unique case (state_q)
            ST_RUN: begin
                if (mem_req_MEM && !dmem_ready) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = ST_RUN;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d   = ST_ERROR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_ERROR: begin
                // Only reset leaves ERROR; dmem_ready is deliberately ignored.
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        ctrl = '0;

        mem_stall = ((state_q == ST_RUN) && mem_req_MEM && !dmem_ready) ||
                    ((state_q == ST_MEM_WAIT) && !dmem_ready) ||
                    (state_q == ST_ERROR);
        load_use  = is_load_use(MemRead_EX, rd_EX, rs1_ID, use_rs1_ID,
                                rs2_ID, use_rs2_ID);

        // Lower-priority hazards are simply dropped here; their inputs stay
        // held by the stall, so they are seen again on a later cycle.
        branch_flush = 1'b0;
        if (reset) begin
            ctrl = '0;
        end else if (mem_stall) begin
            ctrl.stall_pc     = 1'b1;
            ctrl.stall_if_id  = 1'b1;
            ctrl.stall_id_ex  = 1'b1;
            ctrl.stall_ex_mem = 1'b1;
            ctrl.flush_mem_wb = 1'b1;
        end else if (branch_taken_EX) begin
            ctrl.flush_if_id = 1'b1;
            ctrl.flush_id_ex = 1'b1;
            branch_flush     = 1'b1;
        end else if (load_use) begin
            ctrl.stall_pc    = 1'b1;
            ctrl.stall_if_id = 1'b1;
            ctrl.flush_id_ex = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    // NOTE: non-blocking '<=' so every flop samples pre-edge values and the
    // update order between registers does not matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
        end
    end

    // ---------------------------------------------------------------------
    // Performance counters
    // ---------------------------------------------------------------------
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (ctrl.stall_pc),
        .count (stall_cycles)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (branch_flush),
        .count (flush_count)
    );

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign stall_PC     = ctrl.stall_pc;
    assign stall_IF_ID  = ctrl.stall_if_id;
    assign stall_ID_EX  = ctrl.stall_id_ex;
    assign stall_EX_MEM = ctrl.stall_ex_mem;
    assign flush_IF_ID  = ctrl.flush_if_id;
    assign flush_ID_EX  = ctrl.flush_id_ex;
    assign flush_MEM_WB = ctrl.flush_mem_wb;
    assign state        = state_q;
    assign mem_err      = mem_err_q;

endmodule
